// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: word width, MEM-stage FSM states and the
// default memory timeout.
package pipeline_pkg;

    localparam int XLEN            = 32;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } mem_state_e;

    // Memory is word-addressed on the bus; byte offset bits are forced to zero.
    function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] byte_addr);
        return {byte_addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: load captures all fields, bubble clears the
// control fields only, otherwise the register holds.
module mem_wb_reg
    import pipeline_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            bubble,
    input  logic [XLEN-1:0] read_data_in,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [4:0]      write_reg_in,
    input  logic            reg_write_in,
    input  logic            mem_to_reg_in,
    output logic [XLEN-1:0] read_data_out,
    output logic [XLEN-1:0] alu_result_out,
    output logic [4:0]      write_reg_out,
    output logic            reg_write_out,
    output logic            mem_to_reg_out
);

    logic [XLEN-1:0] read_data_d,  read_data_q;
    logic [XLEN-1:0] alu_result_d, alu_result_q;
    logic [4:0]      write_reg_d,  write_reg_q;
    logic            reg_write_d,  reg_write_q;
    logic            mem_to_reg_d, mem_to_reg_q;

    always_comb begin
        read_data_d  = read_data_q;
        alu_result_d = alu_result_q;
        write_reg_d  = write_reg_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        if (load) begin
            read_data_d  = read_data_in;
            alu_result_d = alu_result_in;
            write_reg_d  = write_reg_in;
            reg_write_d  = reg_write_in;
            mem_to_reg_d = mem_to_reg_in;
        end else if (bubble) begin
            write_reg_d  = '0;
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_data_q  <= '0;
            alu_result_q <= '0;
            write_reg_q  <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            write_reg_q  <= write_reg_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    assign read_data_out  = read_data_q;
    assign alu_result_out = alu_result_q;
    assign write_reg_out  = write_reg_q;
    assign reg_write_out  = reg_write_q;
    assign mem_to_reg_out = mem_to_reg_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one data-memory request per load/store, stalls
// the front of the pipeline until ack or timeout, and feeds MEM/WB.
module mem_access_stage
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] write_data_in,
    input  logic [4:0]      write_reg_in,
    input  logic            reg_write_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic            mem_to_reg_in,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            stall,
    output logic [XLEN-1:0] read_data_out,
    output logic [XLEN-1:0] alu_result_out,
    output logic [4:0]      write_reg_out,
    output logic            reg_write_out,
    output logic            mem_to_reg_out,
    output logic            err_align,
    output logic            err_timeout
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

    mem_state_e      state_d, state_q;
    logic            req_d, req_q;
    logic            we_d, we_q;
    logic [XLEN-1:0] addr_d, addr_q;
    logic [XLEN-1:0] wdata_d, wdata_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic            err_align_d, err_align_q;
    logic            err_timeout_d, err_timeout_q;

    logic            memop, aligned, timeout_hit;
    logic            wb_load, wb_bubble;
    logic [XLEN-1:0] wb_rdata;

    assign memop       = mem_read_in | mem_write_in;
    assign aligned     = (alu_result_in[1:0] == 2'b00);
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        cnt_d         = cnt_q;
        err_align_d   = err_align_q;
        err_timeout_d = err_timeout_q;
        wb_load       = 1'b0;
        wb_bubble     = 1'b0;
        wb_rdata      = '0;
        stall         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!memop) begin
                    wb_load = 1'b1;
                end else if (aligned) begin
                    stall   = 1'b1;
                    wb_bubble = 1'b1;
                    req_d   = 1'b1;
                    // A simultaneous read+write is treated as a store.
                    we_d    = mem_write_in;
                    addr_d  = word_addr(alu_result_in);
                    wdata_d = write_data_in;
                    cnt_d   = '0;
                    state_d = S_ACCESS;
                end else begin
                    wb_bubble   = 1'b1;
                    err_align_d = 1'b1;
                end
            end
            S_ACCESS: begin
                if (dmem_ack) begin
                    wb_load  = 1'b1;
                    wb_rdata = we_q ? '0 : dmem_rdata;
                    req_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end else if (timeout_hit) begin
                    wb_bubble     = 1'b1;
                    req_d         = 1'b0;
                    err_timeout_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = S_IDLE;
                end else begin
                    stall     = 1'b1;
                    wb_bubble = 1'b1;
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (reset) stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            cnt_q         <= '0;
            err_align_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
            err_align_q   <= err_align_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign err_align   = err_align_q;
    assign err_timeout = err_timeout_q;

    mem_wb_reg u_mem_wb (
        .clk            (clk),
        .reset          (reset),
        .load           (wb_load),
        .bubble         (wb_bubble),
        .read_data_in   (wb_rdata),
        .alu_result_in  (alu_result_in),
        .write_reg_in   (write_reg_in),
        .reg_write_in   (reg_write_in),
        .mem_to_reg_in  (mem_to_reg_in),
        .read_data_out  (read_data_out),
        .alu_result_out (alu_result_out),
        .write_reg_out  (write_reg_out),
        .reg_write_out  (reg_write_out),
        .mem_to_reg_out (mem_to_reg_out)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a short memory timeout of 4 cycles.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_result_in, write_data_in, dmem_rdata;
    logic [4:0]  write_reg_in;
    logic        reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, dmem_ack;
    logic        dmem_req, dmem_we, stall;
    logic [31:0] dmem_addr, dmem_wdata, read_data_out, alu_result_out;
    logic [4:0]  write_reg_out;
    logic        reg_write_out, mem_to_reg_out, err_align, err_timeout;

    int checks = 0;
    int passed = 0;
    int stall_cnt;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .alu_result_in(alu_result_in), .write_data_in(write_data_in),
        .write_reg_in(write_reg_in), .reg_write_in(reg_write_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_to_reg_in(mem_to_reg_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .read_data_out(read_data_out),
        .alu_result_out(alu_result_out), .write_reg_out(write_reg_out),
        .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
        .err_align(err_align), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                         input logic rw, input logic mr, input logic mw, input logic m2r);
        alu_result_in = alu;
        write_data_in = wd;
        write_reg_in  = wr;
        reg_write_in  = rw;
        mem_read_in   = mr;
        mem_write_in  = mw;
        mem_to_reg_in = m2r;
    endtask

    task automatic nop();
        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        nop();
        #1;
        chk("stall_in_reset", {31'b0, stall}, 32'd0);
        step();
        step();
        chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'h0);
        chk("rst_rdata_out", read_data_out, 32'h0);
        chk("rst_reg_write", {31'b0, reg_write_out}, 32'd0);
        chk("rst_errs", {30'b0, err_align, err_timeout}, 32'd0);
        reset = 1'b0;

        // ALU op: one-cycle pass-through, no stall
        drive(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 chk("alu_stall", {31'b0, stall}, 32'd0);
        step();
        chk("alu_reg_write", {31'b0, reg_write_out}, 32'd1);
        chk("alu_write_reg", {27'b0, write_reg_out}, 32'd5);
        chk("alu_result", alu_result_out, 32'h1234);
        chk("alu_rdata_zero", read_data_out, 32'h0);
        chk("alu_no_req", {31'b0, dmem_req}, 32'd0);

        // Load 0x100, acked in first ACCESS cycle
        drive(32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        #1 chk("ld_stall_idle", {31'b0, stall}, 32'd1);
        step();
        chk("ld_req", {31'b0, dmem_req}, 32'd1);
        chk("ld_we", {31'b0, dmem_we}, 32'd0);
        chk("ld_addr", dmem_addr, 32'h100);
        chk("ld_bubble_rw", {31'b0, reg_write_out}, 32'd0);
        chk("ld_bubble_wr", {27'b0, write_reg_out}, 32'd0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1 chk("ld_stall_ack", {31'b0, stall}, 32'd0);
        step();
        dmem_ack = 1'b0;
        chk("ld_req_drop", {31'b0, dmem_req}, 32'd0);
        chk("ld_rdata", read_data_out, 32'hDEADBEEF);
        chk("ld_mem_to_reg", {31'b0, mem_to_reg_out}, 32'd1);
        chk("ld_write_reg", {27'b0, write_reg_out}, 32'd7);
        chk("ld_reg_write", {31'b0, reg_write_out}, 32'd1);
        nop();

        // Store 0x200, ack after 3 wait cycles
        drive(32'h200, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        stall_cnt = 0;
        #1 stall_cnt += int'(stall);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("st_req_hold", {31'b0, dmem_req}, 32'd1);
            chk("st_we_hold", {31'b0, dmem_we}, 32'd1);
            chk("st_addr_hold", dmem_addr, 32'h200);
            chk("st_wdata_hold", dmem_wdata, 32'hA5A5A5A5);
            #1 stall_cnt += int'(stall);
            step();
        end
        chk("st_req_ackcyc", {31'b0, dmem_req}, 32'd1);
        chk("st_wdata_ackcyc", dmem_wdata, 32'hA5A5A5A5);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h55555555;
        #1 stall_cnt += int'(stall);
        chk("st_stall_cycles", stall_cnt, 32'd4);
        step();
        dmem_ack = 1'b0;
        chk("st_req_drop", {31'b0, dmem_req}, 32'd0);
        chk("st_reg_write", {31'b0, reg_write_out}, 32'd0);
        chk("st_rdata_zero", read_data_out, 32'h0);
        nop();

        // Read and write together: executed as a store
        drive(32'h303, 32'h0BADF00D, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1);
        alu_result_in = 32'h300;
        step();
        chk("rw_we", {31'b0, dmem_we}, 32'd1);
        chk("rw_wdata", dmem_wdata, 32'h0BADF00D);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h12121212;
        step();
        dmem_ack = 1'b0;
        chk("rw_rdata_zero", read_data_out, 32'h0);
        nop();

        // Misaligned load
        drive(32'h102, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
        #1 chk("mis_stall", {31'b0, stall}, 32'd0);
        step();
        chk("mis_no_req", {31'b0, dmem_req}, 32'd0);
        chk("mis_err_align", {31'b0, err_align}, 32'd1);
        chk("mis_bubble_rw", {31'b0, reg_write_out}, 32'd0);
        chk("mis_bubble_m2r", {31'b0, mem_to_reg_out}, 32'd0);
        nop();
        step();
        chk("mis_sticky", {31'b0, err_align}, 32'd1);

        // Load never acked: timeout after 4 request cycles
        drive(32'h400, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("to_req", {31'b0, dmem_req}, 32'd1);
            #1 chk("to_stall", {31'b0, stall}, (i < 3) ? 32'd1 : 32'd0);
            step();
        end
        chk("to_req_drop", {31'b0, dmem_req}, 32'd0);
        chk("to_err", {31'b0, err_timeout}, 32'd1);
        chk("to_bubble_rw", {31'b0, reg_write_out}, 32'd0);
        // Back in IDLE: ALU op passes in one cycle and a stray ack is ignored
        drive(32'h77, 32'h0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        #1 chk("to_idle_stall", {31'b0, stall}, 32'd0);
        step();
        dmem_ack = 1'b0;
        chk("idle_ack_rdata", read_data_out, 32'h0);
        chk("idle_alu_wr", {27'b0, write_reg_out}, 32'd11);
        chk("idle_no_req", {31'b0, dmem_req}, 32'd0);

        // Reset during second ACCESS cycle, ack arrives after reset
        drive(32'h500, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        step();
        reset = 1'b1;
        #1 chk("rst_acc_stall", {31'b0, stall}, 32'd0);
        step();
        reset = 1'b0;
        nop();
        chk("rst_acc_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_acc_errs", {30'b0, err_align, err_timeout}, 32'd0);
        chk("rst_acc_alu", alu_result_out, 32'h0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h12345678;
        step();
        dmem_ack = 1'b0;
        chk("rst_ack_ignored", read_data_out, 32'h0);
        chk("rst_ack_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_ack_rw", {31'b0, reg_write_out}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 TIMEOUT_CYCLES, default 255, max ACCESS cycles waiting for dmem_ack before abort.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 alu_result_in  in  32  EX/MEM ALU result; memory byte address for loads/stores.
REQ-005 write_data_in  in  32  EX/MEM store data.
REQ-006 write_reg_in  in  5  EX/MEM destination register.
REQ-007 reg_write_in  in  1  EX/MEM register-write enable.
REQ-008 mem_read_in  in  1  EX/MEM load.
REQ-009 mem_write_in  in  1  EX/MEM store.
REQ-010 mem_to_reg_in  in  1  EX/MEM writeback select.
REQ-011 dmem_req  out  1  data-memory request, registered.
REQ-012 dmem_we  out  1  1 = write, 0 = read; valid while dmem_req.
REQ-013 dmem_addr  out  32  word-aligned byte address; valid while dmem_req.
REQ-014 dmem_wdata  out  32  store data; valid while dmem_req.
REQ-015 dmem_ack  in  1  memory completion, single-cycle pulse.
REQ-016 dmem_rdata  in  32  load data, valid in the dmem_ack cycle.
REQ-017 stall  out  1  combinational; holds PC, IF/ID, ID/EX and EX/MEM.
REQ-018 read_data_out  out  32  MEM/WB load data.
REQ-019 alu_result_out  out  32  MEM/WB ALU result.
REQ-020 write_reg_out  out  5  MEM/WB destination register.
REQ-021 reg_write_out  out  1  MEM/WB register-write enable.
REQ-022 mem_to_reg_out  out  1  MEM/WB writeback select.
REQ-023 err_align  out  1  sticky misaligned-access flag.
REQ-024 err_timeout  out  1  sticky memory-timeout flag.

Function
REQ-025 The FSM SHALL have states IDLE and ACCESS.
- memop = mem_read_in | mem_write_in.
- aligned = alu_result_in[1:0]==0.
REQ-026 IDLE, memop=0: MEM/WB SHALL capture the inputs next edge and set read_data_out=0 (1-cycle latency, no stall).
REQ-027 IDLE, memop=1, aligned: next edge SHALL register dmem_req=1, dmem_we=mem_write_in, dmem_addr, dmem_wdata, enter ACCESS, and load a bubble into MEM/WB; stall=1 this cycle.
REQ-028 mem_read_in and mem_write_in both 1 SHALL be executed as a store.
REQ-029 IDLE, memop=1, misaligned: no request; next edge SHALL set err_align=1 and load a bubble; stall=0.
REQ-030 ACCESS, dmem_ack=0: hold dmem_* stable, increment wait counter, load a bubble; stall=1.
REQ-031 ACCESS, dmem_ack=1: stall=0 that cycle; next edge SHALL capture the EX/MEM fields plus read_data_out=dmem_rdata (loads) or 0 (stores), drop dmem_req, clear counter, enter IDLE.
- Load with ack in its first ACCESS cycle: exactly 1 stall cycle.
REQ-032 ACCESS, counter==TIMEOUT_CYCLES-1 and dmem_ack=0: next edge SHALL drop dmem_req, set err_timeout=1, load a bubble, enter IDLE; stall=0 that cycle.
REQ-033 Bubble = reg_write_out=0, mem_to_reg_out=0, write_reg_out=0; data fields don't-care.
REQ-034 dmem_ack in IDLE SHALL be ignored.
REQ-035 Counter SHALL be 8 bits wide minimum and SHALL NOT wrap.

Reset
REQ-036 reset=1 SHALL, at the next edge, force IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, all MEM/WB outputs 0, counter 0, err_align=0, err_timeout=0; stall=0 while reset=1.
REQ-037 reset during ACCESS SHALL abandon the request; a later dmem_ack SHALL be ignored.

Structure
REQ-038 The state enum, word width 32 and default TIMEOUT_CYCLES SHALL reside in shared package pipeline_pkg.
REQ-039 The MEM/WB output register SHALL be one sub-module, mem_wb_reg, with load/bubble controls.

Verification
REQ-040 ALU op, reg_write_in=1, write_reg_in=5, alu_result_in=0x1234 -> next cycle reg_write_out=1, write_reg_out=5, alu_result_out=0x1234, stall never 1.
REQ-041 Load addr 0x100, ack 1st ACCESS cycle, rdata=0xDEADBEEF -> dmem_req 1 cycle, stall 1 cycle, read_data_out=0xDEADBEEF, mem_to_reg_out=1.
REQ-042 Store addr 0x200, data 0xA5A5A5A5, ack after 3 wait cycles -> dmem_we=1, dmem_* stable 4 cycles, stall 4 cycles, reg_write_out=0.
REQ-043 Load addr 0x102 -> no dmem_req, err_align=1, stall=0, bubble.
REQ-044 TIMEOUT_CYCLES=4, load never acked -> dmem_req 4 cycles then 0, err_timeout=1, bubble, IDLE.
REQ-045 reset pulsed in 2nd ACCESS cycle, ack one cycle later -> all outputs 0, ack ignored, MEM/WB unchanged.
